uart_telemetry_tx: RTL and testbench

UART_TELEMETRY_TX -- requirements
Module: uart_telemetry_tx

---
 rtl/uart_telem_pkg.sv | 22 ++
 rtl/uart_byte_tx.sv | 119 +++++++++++
 rtl/uart_telemetry_tx.sv | 148 ++++++++++++++
 tb/tb_uart_telemetry_tx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_telem_pkg.sv
// Shared definitions for the UART telemetry transmitter.
//   SYNC_BYTE   : first byte of every frame
//   tx_state_e  : byte serializer states
//   frame_len() : bytes per frame for a given channel count / checksum option
package uart_telem_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  // Sync byte + two bytes per channel + optional checksum byte.
  function automatic int unsigned frame_len(input int unsigned n_ch,
                                            input int unsigned csum_en);
    return 2 * n_ch + 1 + csum_en;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer, LSB first, line idle high.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   valid_i       : byte offered on data_i
//   data_i [7:0]  : byte to send
//   ready_o       : byte accepted this cycle when valid_i is also high
//   tx_o          : serial line (registered)
//   stop_end_o    : last cycle of a stop bit
// ready_o is also high in the final stop-bit cycle so that back-to-back
// bytes follow with no idle gap.
module uart_byte_tx
  import uart_telem_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       stop_end_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  assign bit_end    = (cnt_q == CNT_LAST);
  assign ready_o    = (state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end);
  assign stop_end_o = (state_q == ST_STOP) && bit_end;
  assign tx_o       = tx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (valid_i) begin
          state_d = ST_START;
          sh_d    = data_i;
          cnt_d   = '0;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = sh_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
            tx_d  = sh_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (valid_i) begin
            state_d = ST_START;
            sh_d    = data_i;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/uart_telemetry_tx.sv
// Periodic / on-demand telemetry framer over a UART line.
// Frame: 0xA5, then per channel high and low byte (zero-extended to 16 bits),
// then optional XOR checksum of the data bytes.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   enable          : allows periodic ticks and external triggers
//   trig            : one-cycle external frame request
//   ch_data         : packed channels, channel k at [k*CH_W +: CH_W]
//   ovr_clr         : clears overrun
//   uart_tx         : serial line, 8N1, idle high
//   busy            : frame in flight
//   frame_done      : one-cycle pulse after the last stop bit
//   overrun         : sticky, a trigger was dropped
module uart_telemetry_tx
  import uart_telem_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT  = 234,
  parameter int unsigned N_CH          = 2,
  parameter int unsigned CH_W          = 15,
  parameter int unsigned PERIOD_CYCLES = 1048576,
  parameter int unsigned CSUM_EN       = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 trig,
  input  logic [N_CH*CH_W-1:0] ch_data,
  input  logic                 ovr_clr,
  output logic                 uart_tx,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam int unsigned LEN   = frame_len(N_CH, CSUM_EN);
  localparam int unsigned IDX_W = $clog2(LEN + 1);
  localparam int unsigned PER_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYCLES - 1);

  logic [PER_W-1:0]       per_q, per_d;
  logic [N_CH*CH_W-1:0]   snap_q, snap_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ovr_q, ovr_d;

  logic                   tick, trigger, accept;
  logic [15:0]            ch16 [N_CH];
  logic [7:0]             csum, tx_byte;
  logic                   ser_valid, ser_ready, ser_stop_end;
  logic                   last_idx;

  assign tick     = enable && (per_q == PER_LAST);
  // tick and trig in the same cycle collapse into a single request
  assign trigger  = enable && (tick || trig);
  // the frame_done cycle still counts as busy for trigger acceptance
  assign accept   = trigger && !busy_q && !done_q;
  assign last_idx = (idx_q == IDX_W'(LEN));

  always_comb begin
    for (int unsigned k = 0; k < N_CH; k++) begin
      ch16[k] = 16'(snap_q[k*CH_W +: CH_W]);
    end
  end

  always_comb begin
    csum = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      csum = csum ^ ch16[k][15:8] ^ ch16[k][7:0];
    end
  end

  // idx_q is 0 whenever idle, so the sync byte is ready for the accept cycle.
  always_comb begin
    tx_byte = SYNC_BYTE;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (32'(idx_q) == 2 * k + 1) tx_byte = ch16[k][15:8];
      if (32'(idx_q) == 2 * k + 2) tx_byte = ch16[k][7:0];
    end
    if ((CSUM_EN != 0) && (32'(idx_q) == LEN - 1)) tx_byte = csum;
  end

  assign ser_valid = busy_q ? !last_idx : accept;

  always_comb begin
    per_d  = per_q;
    snap_d = snap_q;
    idx_d  = idx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    ovr_d  = ovr_q;

    if (!enable || tick) per_d = '0;
    else                 per_d = per_q + 1'b1;

    if (accept) begin
      snap_d = ch_data;
      idx_d  = IDX_W'(1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (ser_valid && ser_ready) begin
        idx_d = idx_q + 1'b1;
      end else if (last_idx && ser_stop_end) begin
        idx_d  = '0;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end

    if (trigger && (busy_q || done_q)) ovr_d = 1'b1;
    else if (ovr_clr)                  ovr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_q  <= '0;
      snap_q <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      per_q  <= per_d;
      snap_q <= snap_d;
      idx_q  <= idx_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ovr_q  <= ovr_d;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (ser_valid),
    .data_i     (tx_byte),
    .ready_o    (ser_ready),
    .tx_o       (uart_tx),
    .stop_end_o (ser_stop_end)
  );

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_telemetry_tx.sv
module tb_uart_telemetry_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // a: trigger tests, b: periodic tests, c: one channel without checksum
  logic        enable_a, trig_a, ovr_clr_a, tx_a, busy_a, fd_a, ovr_a;
  logic [29:0] ch_a;
  logic        enable_b, trig_b, ovr_clr_b, tx_b, busy_b, fd_b, ovr_b;
  logic [29:0] ch_b;
  logic        enable_c, trig_c, ovr_clr_c, tx_c, busy_c, fd_c, ovr_c;
  logic [11:0] ch_c;

  uart_telemetry_tx #(.CLKS_PER_BIT(CPB), .N_CH(2), .CH_W(15),
                      .PERIOD_CYCLES(50000), .CSUM_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable_a), .trig(trig_a), .ch_data(ch_a),
    .ovr_clr(ovr_clr_a), .uart_tx(tx_a), .busy(busy_a), .frame_done(fd_a), .overrun(ovr_a));

  uart_telemetry_tx #(.CLKS_PER_BIT(CPB), .N_CH(2), .CH_W(15),
                      .PERIOD_CYCLES(300), .CSUM_EN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .trig(trig_b), .ch_data(ch_b),
    .ovr_clr(ovr_clr_b), .uart_tx(tx_b), .busy(busy_b), .frame_done(fd_b), .overrun(ovr_b));

  uart_telemetry_tx #(.CLKS_PER_BIT(CPB), .N_CH(1), .CH_W(12),
                      .PERIOD_CYCLES(50000), .CSUM_EN(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .enable(enable_c), .trig(trig_c), .ch_data(ch_c),
    .ovr_clr(ovr_clr_c), .uart_tx(tx_c), .busy(busy_c), .frame_done(fd_c), .overrun(ovr_c));

  int n_vec = 0;
  int n_err = 0;

  localparam logic [47:0] EXP_A = 48'hA5_12_34_7F_FF_A6;
  localparam logic [47:0] EXP_B = 48'hA5_55_55_0A_BC_B6;
  localparam logic [47:0] EXP_C = 48'hA5_0A_BC_00_00_00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic line(input int s);
    case (s)
      0:       return tx_a;
      1:       return tx_b;
      default: return tx_c;
    endcase
  endfunction

  function automatic logic bsy(input int s);
    case (s)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic fdn(input int s);
    case (s)
      0:       return fd_a;
      1:       return fd_b;
      default: return fd_c;
    endcase
  endfunction

  task automatic set_trig(input int s, input logic v);
    case (s)
      0:       trig_a = v;
      1:       trig_b = v;
      default: trig_c = v;
    endcase
  endtask

  // 1: zero ch_a, 2: trig_a pulse, 3: trig_a + ovr_clr_a pulse, 4: drop enable_b
  task automatic do_action(input int act, input logic on);
    case (act)
      1: if (on) ch_a = '0;
      2: trig_a = on;
      3: begin trig_a = on; ovr_clr_a = on; end
      4: if (on) enable_b = 1'b0;
      default: ;
    endcase
  endtask

  // Returns at the negedge of start-bit cycle 0 of the accepted frame.
  task automatic pulse_trig(input int s);
    set_trig(s, 1'b1);
    @(negedge clk);
    set_trig(s, 1'b0);
  endtask

  // Entered at the negedge of start-bit cycle 0; samples mid-bit on a fixed
  // grid so any gap or stretched bit shows up as a wrong byte.
  task automatic recv_frame(input int s, input int nb, input logic [47:0] exp,
                            input int act_at, input int act);
    logic [9:0] sh;
    int bad_busy, bp, bi;
    sh = '0;
    bad_busy = 0;
    for (int n = 0; n < nb * 10 * CPB; n++) begin
      if (n == act_at)     do_action(act, 1'b1);
      if (n == act_at + 1) do_action(act, 1'b0);
      if (bsy(s) !== 1'b1) bad_busy++;
      if (n % CPB == CPB / 2) begin
        bp = (n / CPB) % 10;
        sh[bp] = line(s);
        if (bp == 9) begin
          bi = n / (10 * CPB);
          check($sformatf("dut%0d_byte%0d", s, bi), 32'(sh[8:1]), 32'(exp[47 - 8 * bi -: 8]));
          check($sformatf("dut%0d_framing%0d", s, bi), 32'({sh[9], sh[0]}), 32'd2);
        end
      end
      @(negedge clk);
    end
    check($sformatf("dut%0d_busy_held", s), 32'(bad_busy), 32'd0);
  endtask

  // Entered in the cycle right after the last stop bit.
  task automatic end_check(input int s, input logic poke);
    check($sformatf("dut%0d_busy_fall", s), 32'(bsy(s)), 32'd0);
    check($sformatf("dut%0d_done_pulse", s), 32'(fdn(s)), 32'd1);
    if (poke) set_trig(s, 1'b1);
    @(negedge clk);
    if (poke) set_trig(s, 1'b0);
    check($sformatf("dut%0d_done_clear", s), 32'(fdn(s)), 32'd0);
  endtask

  task automatic expect_idle(input int s, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (line(s) !== 1'b1 || bsy(s) !== 1'b0) bad++;
      @(negedge clk);
    end
    check($sformatf("dut%0d_idle", s), 32'(bad), 32'd0);
  endtask

  task automatic wait_start(input int s, input int limit);
    for (int k = 0; k < limit; k++) begin
      if (line(s) === 1'b0) break;
      @(negedge clk);
    end
  endtask

  initial begin
    int c0, t1;
    rst_n = 1'b0;
    enable_a = 1'b1; trig_a = 1'b0; ovr_clr_a = 1'b0; ch_a = {15'h7FFF, 15'h1234};
    enable_b = 1'b0; trig_b = 1'b0; ovr_clr_b = 1'b0; ch_b = {15'h0ABC, 15'h5555};
    enable_c = 1'b1; trig_c = 1'b0; ovr_clr_c = 1'b0; ch_c = 12'hABC;

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx_a), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(fd_a), 32'd0);
    check("rst_ovr", 32'(ovr_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    expect_idle(0, 20);

    // basic frame
    pulse_trig(0);
    check("start_low", 32'(tx_a), 32'd0);
    check("busy_rise", 32'(busy_a), 32'd1);
    recv_frame(0, 6, EXP_A, -1, 0);
    end_check(0, 1'b0);
    check("ovr_quiet", 32'(ovr_a), 32'd0);

    // trig mid-frame is dropped
    pulse_trig(0);
    recv_frame(0, 6, EXP_A, 50, 2);
    end_check(0, 1'b0);
    check("ovr_set", 32'(ovr_a), 32'd1);
    expect_idle(0, 50);
    ovr_clr_a = 1'b1;
    @(negedge clk);
    ovr_clr_a = 1'b0;
    check("ovr_clr", 32'(ovr_a), 32'd0);

    // set and clear together: set wins
    pulse_trig(0);
    recv_frame(0, 6, EXP_A, 50, 3);
    end_check(0, 1'b0);
    check("ovr_set_wins", 32'(ovr_a), 32'd1);
    ovr_clr_a = 1'b1;
    @(negedge clk);
    ovr_clr_a = 1'b0;
    check("ovr_clr2", 32'(ovr_a), 32'd0);

    // snapshot holds after ch_data changes; trig in frame_done cycle dropped
    pulse_trig(0);
    recv_frame(0, 6, EXP_A, 20, 1);
    end_check(0, 1'b1);
    check("ovr_done_cycle", 32'(ovr_a), 32'd1);
    expect_idle(0, 50);
    ch_a = {15'h7FFF, 15'h1234};

    // reset during DATA
    pulse_trig(0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(tx_a), 32'd1);
    check("midrst_busy", 32'(busy_a), 32'd0);
    check("midrst_ovr", 32'(ovr_a), 32'd0);
    check("midrst_done", 32'(fd_a), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expect_idle(0, 80);

    // periodic ticks, then enable dropped mid-frame
    c0 = cyc;
    enable_b = 1'b1;
    wait_start(1, 400);
    check("tick_first", 32'(cyc - c0), 32'd300);
    t1 = cyc;
    recv_frame(1, 6, EXP_B, -1, 0);
    end_check(1, 1'b0);
    wait_start(1, 200);
    check("tick_period", 32'(cyc - t1), 32'd300);
    recv_frame(1, 6, EXP_B, 100, 4);
    end_check(1, 1'b0);
    expect_idle(1, 400);
    check("b_ovr", 32'(ovr_b), 32'd0);

    // one channel, no checksum
    pulse_trig(2);
    check("c_start_low", 32'(tx_c), 32'd0);
    recv_frame(2, 3, EXP_C, -1, 0);
    end_check(2, 1'b0);
    expect_idle(2, 30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
